// File: rtl/risc_pkg.sv
// Shared opcode map, InsL sub-codes, step numbers and control types for the multicycle RISC core.
package risc_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned SUB_W  = 2;
    localparam int unsigned STEP_W = 3;

    localparam logic [OPC_W-1:0] OP_ALU    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LHI    = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LLI    = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDRRI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_LDRRR  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_STRRI  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_STRCMP = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ADDI   = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SUBI   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_MOV    = 5'b01011;
    localparam logic [OPC_W-1:0] OP_JMP    = 5'b10000;
    localparam logic [OPC_W-1:0] OP_JALRL  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_JALRR  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JR     = 5'b10011;
    localparam logic [OPC_W-1:0] OP_BCOND  = 5'b11000;
    localparam logic [OPC_W-1:0] OP_BAL    = 5'b11001;
    localparam logic [OPC_W-1:0] OP_SYS    = 5'b11100;

    // InsL sub-codes: ALU flavour, STR/CMP split, and system OutR/HLT split
    localparam logic [SUB_W-1:0] SUB_ADD   = 2'b00;
    localparam logic [SUB_W-1:0] SUB_ADC   = 2'b01;
    localparam logic [SUB_W-1:0] SUB_SUB   = 2'b10;
    localparam logic [SUB_W-1:0] SUB_SBB   = 2'b11;
    localparam logic [SUB_W-1:0] SUB_STRRR = 2'b00;
    localparam logic [SUB_W-1:0] SUB_CMP   = 2'b01;
    localparam logic [SUB_W-1:0] SUB_OUTR  = 2'b00;
    localparam logic [SUB_W-1:0] SUB_HLT   = 2'b01;

    localparam logic [STEP_W-1:0] STEP_FETCH  = 3'd0;
    localparam logic [STEP_W-1:0] STEP_DECODE = 3'd1;
    localparam logic [STEP_W-1:0] STEP_EXEC   = 3'd2;
    localparam logic [STEP_W-1:0] STEP_MEM    = 3'd3;
    localparam logic [STEP_W-1:0] STEP_WB     = 3'd4;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_LOAD_IMM,
        CL_ALU,
        CL_CMP,
        CL_LDR,
        CL_STR,
        CL_BR,
        CL_JAL,
        CL_OUT,
        CL_HLT
    } op_class_t;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } ctrl_state_t;

    // Step at which an instruction of the given class ends
    function automatic logic [STEP_W-1:0] last_step_of(input op_class_t cls);
        case (cls)
            CL_ALU, CL_CMP, CL_STR: last_step_of = STEP_MEM;
            CL_LDR:                 last_step_of = STEP_WB;
            default:                last_step_of = STEP_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decoder: maps (InsM, InsL) to instruction class and last step.
module multicycle_ctrl_decode
    import risc_pkg::*;
(
    input  logic [OPC_W-1:0]  ins_m,
    input  logic [SUB_W-1:0]  ins_l,
    output op_class_t         op_class,
    output logic [STEP_W-1:0] last_step
);

    always_comb begin
        op_class = CL_NOP;
        case (ins_m)
            OP_LHI, OP_LLI, OP_MOV: op_class = CL_LOAD_IMM;
            OP_ALU: begin
                case (ins_l)
                    SUB_ADD, SUB_ADC, SUB_SUB, SUB_SBB: op_class = CL_ALU;
                    default:                            op_class = CL_NOP;
                endcase
            end
            OP_ADDI, OP_SUBI:   op_class = CL_ALU;
            OP_LDRRI, OP_LDRRR: op_class = CL_LDR;
            OP_STRRI:           op_class = CL_STR;
            OP_STRCMP: begin
                if (ins_l == SUB_STRRR) begin
                    op_class = CL_STR;
                end else if (ins_l == SUB_CMP) begin
                    op_class = CL_CMP;
                end
            end
            OP_BCOND, OP_BAL, OP_JMP, OP_JR: op_class = CL_BR;
            OP_JALRL, OP_JALRR:              op_class = CL_JAL;
            OP_SYS: begin
                if (ins_l == SUB_OUTR) begin
                    op_class = CL_OUT;
                end else if (ins_l == SUB_HLT) begin
                    op_class = CL_HLT;
                end
            end
            default: op_class = CL_NOP;
        endcase
        last_step = last_step_of(op_class);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Step sequencer and per-step control strobe generator for the multicycle RISC core.
// Optional: MULTICYCLE_CTRL_MEM_WAIT_EN makes memory steps wait for MemRdy.
module multicycle_ctrl
    import risc_pkg::*;
#(
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned HALT_STICKY = 1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [OPC_W-1:0] InsM,
    input  logic [SUB_W-1:0] InsL,
    input  logic             MemRdy,
    input  logic             Resume,
    output logic [CNT_W-1:0] Cnt,
    output logic             Buff_PC,
    output logic             IR_Ld,
    output logic             PC_Ld,
    output logic             ALUorNot,
    output logic             RegWr,
    output logic             MemRd,
    output logic             MemWr,
    output logic             FlagWr,
    output logic             Halted
);

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_class_t         op_q, op_d;
    logic [STEP_W-1:0] last_q, last_d;
    op_class_t         dec_class;
    logic [STEP_W-1:0] dec_last;
    logic              mem_wait;
    logic              stall;
    logic              is_exec, is_mem, is_wb;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign mem_wait = ~MemRdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = MemRdy;
    assign mem_wait       = 1'b0;
`endif

    multicycle_ctrl_decode u_decode (
        .ins_m     (InsM),
        .ins_l     (InsL),
        .op_class  (dec_class),
        .last_step (dec_last)
    );

    assign is_exec = (cnt_q == CNT_W'(STEP_EXEC));
    assign is_mem  = (cnt_q == CNT_W'(STEP_MEM));
    assign is_wb   = (cnt_q == CNT_W'(STEP_WB));

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            op_q    <= CL_NOP;
            last_q  <= STEP_EXEC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        last_d   = last_q;
        stall    = 1'b0;
        Cnt      = cnt_q;
        Buff_PC  = 1'b0;
        IR_Ld    = 1'b0;
        PC_Ld    = 1'b0;
        ALUorNot = 1'b0;
        RegWr    = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        FlagWr   = 1'b0;
        Halted   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (cnt_q == CNT_W'(STEP_FETCH)) begin
                    IR_Ld = 1'b1;
                    PC_Ld = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_q == CNT_W'(STEP_DECODE)) begin
                    op_d   = dec_class;
                    last_d = dec_last;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    case (op_q)
                        CL_LOAD_IMM: RegWr = is_exec;
                        CL_ALU: begin
                            ALUorNot = is_exec | is_mem;
                            FlagWr   = is_exec;
                            RegWr    = is_mem;
                        end
                        CL_CMP: begin
                            ALUorNot = is_exec;
                            FlagWr   = is_exec;
                        end
                        CL_LDR: begin
                            ALUorNot = is_exec;
                            MemRd    = is_mem;
                            RegWr    = is_wb;
                            stall    = is_mem & mem_wait;
                        end
                        CL_STR: begin
                            ALUorNot = is_exec;
                            MemWr    = is_mem;
                            stall    = is_mem & mem_wait;
                        end
                        CL_BR:  PC_Ld = is_exec;
                        CL_JAL: begin
                            PC_Ld = is_exec;
                            RegWr = is_exec;
                        end
                        default: ;
                    endcase

                    // HLT parks at step 2 without ending; stalls hold the step
                    if (op_q == CL_HLT) begin
                        state_d = ST_HALT;
                    end else if (stall) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == CNT_W'(last_q)) begin
                        Buff_PC = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_W'(STEP_WB)) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
                Halted = 1'b1;
                if ((HALT_STICKY == 0) && Resume) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Reset blanks every output, including the step count
        if (Rst) begin
            Cnt      = '0;
            Buff_PC  = 1'b0;
            IR_Ld    = 1'b0;
            PC_Ld    = 1'b0;
            ALUorNot = 1'b0;
            RegWr    = 1'b0;
            MemRd    = 1'b0;
            MemWr    = 1'b0;
            FlagWr   = 1'b0;
            Halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: sticky and non-sticky HALT instances share stimulus
// and are compared every cycle against a per-instruction step-schedule reference model.
module tb_multicycle_ctrl;

    localparam int NCYC = 4000;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] cnt;
        logic buff, ir, pc, alu, regw, rd, wr, flg, halted;
    } outs_t;

    // Bit k of each mask means the strobe is active at step k
    typedef struct {
        int       n;
        bit       hlt;
        bit [4:0] alu, flg, regw, rd, wr, pc;
    } sched_t;

    logic       clk;
    logic       rst, mem_rdy, resume;
    logic [4:0] ins_m;
    logic [1:0] ins_l;

    logic [2:0] cnt0, cnt1;
    logic buff0, ir0, pc0, alu0, regw0, rd0, wr0, flg0, hlt0;
    logic buff1, ir1, pc1, alu1, regw1, rd1, wr1, flg1, hlt1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int     m_cnt  [2];
    bit     m_halt [2];
    sched_t m_s    [2];
    bit     sticky [2];

    multicycle_ctrl #(.CNT_W(3), .HALT_STICKY(1)) dut_sticky (
        .clk(clk), .Rst(rst), .InsM(ins_m), .InsL(ins_l), .MemRdy(mem_rdy), .Resume(resume),
        .Cnt(cnt0), .Buff_PC(buff0), .IR_Ld(ir0), .PC_Ld(pc0), .ALUorNot(alu0), .RegWr(regw0),
        .MemRd(rd0), .MemWr(wr0), .FlagWr(flg0), .Halted(hlt0)
    );

    multicycle_ctrl #(.CNT_W(3), .HALT_STICKY(0)) dut_resume (
        .clk(clk), .Rst(rst), .InsM(ins_m), .InsL(ins_l), .MemRdy(mem_rdy), .Resume(resume),
        .Cnt(cnt1), .Buff_PC(buff1), .IR_Ld(ir1), .PC_Ld(pc1), .ALUorNot(alu1), .RegWr(regw1),
        .MemRd(rd1), .MemWr(wr1), .FlagWr(flg1), .Halted(hlt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic sched_t sched_of(input logic [4:0] m, input logic [1:0] l);
        sched_t s;
        s = '{n: 2, hlt: 1'b0, alu: 5'b0, flg: 5'b0, regw: 5'b0, rd: 5'b0, wr: 5'b0, pc: 5'b0};
        case (m)
            5'b00001, 5'b00010, 5'b01011: s.regw = 5'b00100;
            5'b00000, 5'b00111, 5'b01000: begin
                s.n = 3; s.alu = 5'b01100; s.flg = 5'b00100; s.regw = 5'b01000;
            end
            5'b00110: begin
                if (l == 2'b01) begin
                    s.n = 3; s.alu = 5'b00100; s.flg = 5'b00100;
                end else if (l == 2'b00) begin
                    s.n = 3; s.alu = 5'b00100; s.wr = 5'b01000;
                end
            end
            5'b00011, 5'b00100: begin
                s.n = 4; s.alu = 5'b00100; s.rd = 5'b01000; s.regw = 5'b10000;
            end
            5'b00101: begin
                s.n = 3; s.alu = 5'b00100; s.wr = 5'b01000;
            end
            5'b11000, 5'b11001, 5'b10000, 5'b10011: s.pc = 5'b00100;
            5'b10001, 5'b10010: begin
                s.pc = 5'b00100; s.regw = 5'b00100;
            end
            5'b11100: if (l == 2'b01) s.hlt = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic bit model_stall(input int i);
        int c;
        c = m_cnt[i];
        return MEMWAIT && (c >= 2) && (c <= 4) && (m_s[i].rd[c] || m_s[i].wr[c]) && !mem_rdy;
    endfunction

    function automatic outs_t model_out(input int i);
        outs_t e;
        int    c;
        e = '0;
        c = m_cnt[i];
        if (rst) return e;
        e.cnt = 3'(c);
        if (m_halt[i]) begin
            e.halted = 1'b1;
        end else if (c == 0) begin
            e.ir = 1'b1;
            e.pc = 1'b1;
        end else if (c >= 2 && c <= 4) begin
            e.alu  = m_s[i].alu[c];
            e.flg  = m_s[i].flg[c];
            e.regw = m_s[i].regw[c];
            e.rd   = m_s[i].rd[c];
            e.wr   = m_s[i].wr[c];
            e.pc   = m_s[i].pc[c];
            e.buff = (c == m_s[i].n) && !m_s[i].hlt && !model_stall(i);
        end
        return e;
    endfunction

    task automatic model_step(input int i);
        if (rst) begin
            m_cnt[i]  = 0;
            m_halt[i] = 1'b0;
            m_s[i]    = sched_of(5'b11111, 2'b11);
        end else if (m_halt[i]) begin
            if (!sticky[i] && resume) begin
                m_cnt[i]  = 0;
                m_halt[i] = 1'b0;
            end
        end else if (m_cnt[i] == 0) begin
            m_cnt[i] = 1;
        end else if (m_cnt[i] == 1) begin
            m_s[i]   = sched_of(ins_m, ins_l);
            m_cnt[i] = 2;
        end else if (m_s[i].hlt) begin
            m_halt[i] = 1'b1;
        end else if (model_stall(i)) begin
            m_cnt[i] = m_cnt[i];
        end else if (m_cnt[i] == m_s[i].n) begin
            m_cnt[i] = 0;
        end else begin
            m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic check_outs(input int i);
        outs_t g, e;
        string p;
        if (i == 0) g = {cnt0, buff0, ir0, pc0, alu0, regw0, rd0, wr0, flg0, hlt0};
        else        g = {cnt1, buff1, ir1, pc1, alu1, regw1, rd1, wr1, flg1, hlt1};
        e = model_out(i);
        p = (i == 0) ? "sticky" : "resume";
        check_val({p, ".Cnt"},      32'(g.cnt),    32'(e.cnt));
        check_val({p, ".Buff_PC"},  32'(g.buff),   32'(e.buff));
        check_val({p, ".IR_Ld"},    32'(g.ir),     32'(e.ir));
        check_val({p, ".PC_Ld"},    32'(g.pc),     32'(e.pc));
        check_val({p, ".ALUorNot"}, 32'(g.alu),    32'(e.alu));
        check_val({p, ".RegWr"},    32'(g.regw),   32'(e.regw));
        check_val({p, ".MemRd"},    32'(g.rd),     32'(e.rd));
        check_val({p, ".MemWr"},    32'(g.wr),     32'(e.wr));
        check_val({p, ".FlagWr"},   32'(g.flg),    32'(e.flg));
        check_val({p, ".Halted"},   32'(g.halted), 32'(e.halted));
    endtask

    logic [4:0] pool [17];

    initial begin
        pool = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                 5'b00111, 5'b01000, 5'b01011, 5'b11000, 5'b11001, 5'b10000, 5'b10001,
                 5'b10010, 5'b10011, 5'b11100};
        sticky[0] = 1'b1;
        sticky[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_halt[i] = 1'b0;
            m_s[i]    = sched_of(5'b11111, 2'b11);
        end

        for (int k = 0; k < NCYC; k++) begin
            cyc     = k;
            rst     = (k < 2) || ($urandom_range(0, 59) == 0);
            mem_rdy = ($urandom_range(0, 9) < 6);
            resume  = ($urandom_range(0, 9) < 3);
            ins_l   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) ins_m = 5'($urandom_range(0, 31));
            else                           ins_m = pool[$urandom_range(0, 16)];
            #1;
            check_outs(0);
            check_outs(1);
            @(posedge clk);
            model_step(0);
            model_step(1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
